// File: rtl/bp_update_queue.sv
// Retire-side branch update queue: captures PHT index/counter snapshots in fetch order,
// emits the saturated counter on resolve, flushes on mispredict. Option: BP_UPDATE_BYPASS_EN.
module bp_update_queue #(
  parameter int DEPTH   = 4,
  parameter int INDEX_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [INDEX_W-1:0]       push_index,
  input  logic [1:0]               push_counter,
  input  logic                     resolve,
  input  logic                     resolve_taken,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     update,
  output logic [INDEX_W-1:0]       updated_index,
  output logic [1:0]               updated_counter,
  output logic                     mispredict
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [1:0]         ctr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head, tail, head_n, tail_n;
  logic [CW-1:0]   count_n;
  entry_t          head_e;
  logic            pop, mis_n, push_ok;
  logic [1:0]      base, sat;

`ifdef BP_UPDATE_BYPASS_EN
  // Last issued write lives in the output registers; only validity needs its own flag.
  logic byp_v;
`endif

  always_comb begin
    head_e  = mem[head];
    pop     = resolve && !empty;
    mis_n   = pop && (head_e.ctr[1] != resolve_taken);
    // A same-edge pop frees a slot, so a full queue still accepts a correct-path push.
    push_ok = push && !mis_n && (!full || pop);
`ifdef BP_UPDATE_BYPASS_EN
    base = (byp_v && updated_index == head_e.index) ? updated_counter : head_e.ctr;
`else
    base = head_e.ctr;
`endif
    if (resolve_taken) sat = (base == 2'b11) ? 2'b11 : base + 2'd1;
    else               sat = (base == 2'b00) ? 2'b00 : base - 2'd1;
    head_n  = head + PW'(pop);
    tail_n  = mis_n ? head + PW'(1) : tail + PW'(push_ok);
    count_n = mis_n ? '0 : count + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= '{index: push_index, ctr: push_counter};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      empty           <= 1'b1;
      full            <= 1'b0;
      update          <= 1'b0;
      mispredict      <= 1'b0;
      updated_index   <= '0;
      updated_counter <= 2'b01;
`ifdef BP_UPDATE_BYPASS_EN
      byp_v           <= 1'b0;
`endif
    end else begin
      head       <= head_n;
      tail       <= tail_n;
      count      <= count_n;
      empty      <= (count_n == '0);
      full       <= (count_n == CW'(DEPTH));
      update     <= pop;
      mispredict <= mis_n;
      if (pop) begin
        updated_index   <= head_e.index;
        updated_counter <= sat;
      end
`ifdef BP_UPDATE_BYPASS_EN
      if (pop) byp_v <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_bp_update_queue.sv
// Self-checking bench for bp_update_queue against a queue-based reference model.
module tb_bp_update_queue;
  localparam int DEPTH = 4;
  localparam int IW    = 10;

  logic          clk = 0;
  logic          rst, push, resolve, resolve_taken;
  logic [IW-1:0] push_index;
  logic [1:0]    push_counter;
  logic          full, empty, update, mispredict;
  logic [2:0]    count;
  logic [IW-1:0] updated_index;
  logic [1:0]    updated_counter;

  int total = 0, bad = 0;

  bp_update_queue #(.DEPTH(DEPTH), .INDEX_W(IW)) dut (
    .clk(clk), .rst(rst), .push(push), .push_index(push_index),
    .push_counter(push_counter), .resolve(resolve), .resolve_taken(resolve_taken),
    .full(full), .empty(empty), .count(count), .update(update),
    .updated_index(updated_index), .updated_counter(updated_counter),
    .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IW-1:0] index; logic [1:0] ctr; } ent_t;
  ent_t          q[$];
  logic          rec_v;
  logic [IW-1:0] rec_idx;
  logic [1:0]    rec_ctr;
  logic          e_upd, e_mis;
  logic [IW-1:0] e_idx;
  logic [1:0]    e_ctr;

  // Reference behaviour for one rising edge, from the queue rules.
  task automatic model(input logic p, input logic [IW-1:0] i, input logic [1:0] c,
                       input logic r, input logic t, input logic rs);
    ent_t e;
    int   b;
    if (rs) begin
      q.delete(); rec_v = 0; e_upd = 0; e_mis = 0; e_idx = 0; e_ctr = 2'b01;
      return;
    end
    e_upd = 0; e_mis = 0;
    if (r && q.size() > 0) begin
      e = q.pop_front();
      b = e.ctr;
`ifdef BP_UPDATE_BYPASS_EN
      if (rec_v && rec_idx == e.index) b = rec_ctr;
`endif
      if (t) b = (b == 3) ? 3 : b + 1;
      else   b = (b == 0) ? 0 : b - 1;
      e_upd = 1; e_idx = e.index; e_ctr = 2'(b);
      e_mis = (e.ctr[1] != t);
      rec_v = 1; rec_idx = e_idx; rec_ctr = e_ctr;
      if (e_mis) q.delete();
    end
    if (p && !e_mis && q.size() < DEPTH) begin
      e.index = i; e.ctr = c; q.push_back(e);
    end
  endtask

  task automatic drive(input logic p, input logic [IW-1:0] i, input logic [1:0] c,
                       input logic r, input logic t, input logic rs = 0);
    push = p; push_index = i; push_counter = c; resolve = r; resolve_taken = t; rst = rs;
    @(posedge clk); #1;
    model(p, i, c, r, t, rs);
    push = 0; resolve = 0; rst = 0;
  endtask

  task automatic test_reset;
    drive(0, 0, 0, 0, 0, 1);
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=10", empty, full); end
    total++; if (update !== 1'b0 || mispredict !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", update, mispredict); end
    total++; if (updated_index !== '0 || updated_counter !== 2'b01) begin bad++; $display("FAIL reset_data got=%h/%b exp=000/01", updated_index, updated_counter); end
  endtask

  task automatic test_basic;
    drive(1, 10'h005, 2'b01, 0, 0);
    total++; if (count !== 3'd1) begin bad++; $display("FAIL basic_push_count got=%0d exp=1", count); end
    drive(0, 0, 0, 1, 1);
    total++; if ({update, updated_index, updated_counter, mispredict} !== {1'b1, 10'h005, 2'b10, 1'b1})
      begin bad++; $display("FAIL basic_mis got=%b/%h/%b/%b exp=1/005/10/1", update, updated_index, updated_counter, mispredict); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL basic_empty got=%b exp=1", empty); end
    drive(1, 10'h011, 2'b11, 0, 0);
    drive(0, 0, 0, 1, 1);
    total++; if ({update, updated_counter, mispredict} !== {1'b1, 2'b11, 1'b0})
      begin bad++; $display("FAIL sat_hi got=%b/%b/%b exp=1/11/0", update, updated_counter, mispredict); end
    drive(1, 10'h012, 2'b00, 0, 0);
    drive(0, 0, 0, 1, 0);
    total++; if ({update, updated_counter, mispredict} !== {1'b1, 2'b00, 1'b0})
      begin bad++; $display("FAIL sat_lo got=%b/%b/%b exp=1/00/0", update, updated_counter, mispredict); end
    drive(0, 0, 0, 0, 0);
    total++; if (update !== 1'b0) begin bad++; $display("FAIL update_idle got=%b exp=0", update); end
  endtask

  task automatic test_full;
    for (int k = 1; k <= 4; k++) drive(1, IW'(k), 2'b11, 0, 0);
    drive(1, 10'h005, 2'b11, 0, 0);
    total++; if (full !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL full_drop got=%b/%0d exp=1/4", full, count); end
    drive(1, 10'h006, 2'b11, 1, 1);
    total++; if (count !== 3'd4 || updated_index !== 10'h001) begin bad++; $display("FAIL full_pushpop got=%0d/%h exp=4/001", count, updated_index); end
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 1, 1);
    total++; if (updated_index !== 10'h006 || updated_index !== e_idx) begin bad++; $display("FAIL full_fifth got=%h exp=006", updated_index); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drain got=%b exp=1", empty); end
  endtask

  task automatic test_flush;
    for (int k = 0; k < 3; k++) drive(1, IW'(10'h100 + k), 2'b00, 0, 0);
    drive(1, 10'h1ff, 2'b00, 1, 1);
    total++; if (mispredict !== 1'b1 || count !== 3'd0 || empty !== 1'b1)
      begin bad++; $display("FAIL flush got=%b/%0d/%b exp=1/0/1", mispredict, count, empty); end
    drive(0, 0, 0, 1, 0);
    total++; if (update !== 1'b0 || mispredict !== 1'b0) begin bad++; $display("FAIL flush_quiet got=%b%b exp=00", update, mispredict); end
    drive(0, 0, 0, 1, 1);
    total++; if (update !== 1'b0) begin bad++; $display("FAIL flush_quiet2 got=%b exp=0", update); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] first;
    // Correct then wrong prediction on one index: the second base shows the bypass.
    drive(1, 10'h020, 2'b10, 0, 0);
    drive(1, 10'h020, 2'b10, 0, 0);
    drive(0, 0, 0, 1, 1);
    first = updated_counter;
    total++; if (first !== 2'b11) begin bad++; $display("FAIL b2b_first got=%b exp=11", first); end
    drive(0, 0, 0, 1, 0);
`ifdef BP_UPDATE_BYPASS_EN
    total++; if (updated_counter !== 2'b10) begin bad++; $display("FAIL b2b_second got=%b exp=10", updated_counter); end
`else
    total++; if (updated_counter !== 2'b01) begin bad++; $display("FAIL b2b_second got=%b exp=01", updated_counter); end
`endif
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL b2b_mis got=%b exp=1", mispredict); end
  endtask

  task automatic test_reset_mid;
    drive(1, 10'h033, 2'b10, 0, 0);
    drive(1, 10'h034, 2'b10, 0, 0);
    drive(0, 0, 0, 1, 1, 1);
    total++; if ({update, empty, updated_counter} !== {1'b0, 1'b1, 2'b01})
      begin bad++; $display("FAIL rst_mid got=%b/%b/%b exp=0/1/01", update, empty, updated_counter); end
    drive(0, 0, 0, 1, 1);
    total++; if (update !== 1'b0) begin bad++; $display("FAIL rst_empty_resolve got=%b exp=0", update); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 99) < 60, IW'($urandom_range(0, 3)), 2'($urandom),
            $urandom_range(0, 99) < 45, 1'($urandom), $urandom_range(0, 99) < 2);
      total++;
      if (count !== 3'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
        bad++; $display("FAIL rnd_occ n=%0d got=%0d/%b/%b exp=%0d", n, count, empty, full, q.size());
      end
      total++;
      if (update !== e_upd || mispredict !== e_mis || (e_upd && (updated_index !== e_idx || updated_counter !== e_ctr))) begin
        bad++; $display("FAIL rnd_upd n=%0d got=%b/%b/%h/%b exp=%b/%b/%h/%b", n,
                        update, mispredict, updated_index, updated_counter, e_upd, e_mis, e_idx, e_ctr);
      end
    end
  endtask

  initial begin
    rst = 1; push = 0; resolve = 0; resolve_taken = 0; push_index = 0; push_counter = 0;
    rec_v = 0; e_upd = 0; e_mis = 0; e_idx = 0; e_ctr = 2'b01;
    @(negedge clk);
    test_reset;
    test_basic;
    test_full;
    test_flush;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bp_update_queue.md
# bp_update_queue

Branch-predictor retire-side buffer sitting directly downstream of the pattern history table. It captures each fetched branch's PHT index and 2-bit counter snapshot in program order. When the branch resolves, it computes the saturated counter and drives the PHT write port (`update`, `updated_index`, `updated_counter`). It also flags mispredictions and discards wrong-path entries.

## Interface
- `DEPTH`, 4: number of in-flight branch entries (power of two, 2..16).
- `INDEX_W`, 10: PHT index width.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `push` input 1: fetch has predicted a branch; enqueue.
- `push_index` input INDEX_W: PHT `index_out` for that branch.
- `push_counter` input 2: PHT `prediction` for that branch.
- `resolve` input 1: oldest in-flight branch has resolved (in order).
- `resolve_taken` input 1: actual outcome of that branch.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `count` output $clog2(DEPTH)+1: occupied entries.
- `update` output 1: PHT write strobe.
- `updated_index` output INDEX_W: PHT write index.
- `updated_counter` output 2: PHT write data.
- `mispredict` output 1: one-cycle pulse; resolved outcome differed from prediction.

## Operation
- Circular FIFO with head/tail pointers wrapping modulo DEPTH. Each entry holds {index, counter}.
- Push is accepted when `push` && !`full`. A push while full is dropped; state is unchanged.
- Resolve is effective when `resolve` && !`empty`. A resolve while empty is ignored and produces no `update`.
- Effective resolve pops the head entry and computes the base counter.
  - Base counter is the entry counter, or the bypass value (see Configuration).
- Saturating arithmetic on the 2-bit base counter:
  - taken: 11 stays 11, else +1.
  - not taken: 00 stays 00, else −1.
- Predicted direction = entry counter bit[1] (the snapshot, never the bypassed value).
- `mispredict` = predicted direction != `resolve_taken`.
- On mispredict, all remaining entries are flushed: count = 0, tail = head+1.
  - A push in the same cycle is wrong-path and is dropped.
- Simultaneous push and effective resolve without mispredict: both happen; count unchanged.
  - Legal when full, because the pop frees the slot in the same edge.
- Reset mid-operation discards all entries; no `update` is issued for them.

## Timing
- All outputs registered.
- Effective resolve sampled at rising edge N: `update`=1 with `updated_index`, `updated_counter`, `mispredict` valid throughout cycle N+1.
  - PHT commits on the falling edge inside N+1.
- Latency resolve→update is 1 cycle. Throughput is one update per cycle.
- `update` and `mispredict` deassert in any cycle with no effective resolve in the prior cycle.
- `count`/`full`/`empty` reflect push/pop/flush of edge N from N+1.
- Reset values (cycle after `rst` sampled high):
  - `update`=0, `mispredict`=0
  - `updated_index`=0, `updated_counter`=2'b01
  - `count`=0, `empty`=1, `full`=0
  - head=tail=0; bypass record invalid.

## Configuration
- `BP_UPDATE_BYPASS_EN` defined: the block keeps a last-write record {valid, index, counter}, set on every issued update and cleared by reset.
  - If the popped entry index equals the record index and the record is valid, the base counter is the record counter. This prevents back-to-back branches on one index from writing a stale snapshot.
- Undefined: base counter is always the entry snapshot; no record exists.

## Test plan
- Reset, then push {idx 0x005, ctr 01}, resolve taken next cycle: one cycle later `update`=1, `updated_index`=0x005, `updated_counter`=10, `mispredict`=1; queue empty.
- Push ctr 11 then resolve taken: `updated_counter`=11, `mispredict`=0. Push ctr 00 then resolve not-taken: `updated_counter`=00, `mispredict`=0.
- Fill 4 entries, push 5th: dropped, `full`=1, `count`=4. Then push and resolve same cycle (correct prediction): `count` stays 4, and the 5th pop returns the new entry.
- Three entries queued, head mispredicts: `mispredict` pulse, `count`=0 next cycle, a same-cycle push is dropped, and no further updates appear.
- Two entries on idx 0x020 (both snapshot 10), resolved taken back-to-back: with `BP_UPDATE_BYPASS_EN` updates are 11 then 11; without it, 11 then 11 from stale 10. Repeat with snapshot 01: with the macro 10 then 11; without it 10 then 10.
- Assert `rst` with 2 entries queued and a resolve pending: next cycle `update`=0, `empty`=1, `updated_counter`=01; a resolve while empty produces no update.
